// File: rtl/cordic_pkg.sv
// Shared definitions for the linear-mode CORDIC blocks (multiply and
// reciprocal/division). Holds the default fixed-point format, the
// four-state sequencing encoding, the output saturation limits and the
// Q6.11 representation of 1.0.
package cordic_pkg;

  localparam int WORD_LENGTH_DEF = 18;
  localparam int FRAC_BITS_DEF   = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_e;

  localparam logic [WORD_LENGTH_DEF-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [WORD_LENGTH_DEF-1:0] SAT_MIN = 18'h20000;
  localparam logic [WORD_LENGTH_DEF-1:0] ONE_Q   = 18'd2048;

endpackage

// File: rtl/cordic_norm_shift.sv
// Leading-sign detector for the CORDIC operand normaliser.
// Returns the smallest shift k in 0..MAX_SHIFT for which din >>> k lies in
// the CORDIC linear convergence range [-2.0, 2.0).
// Ports:
//   din  in   WORD_LENGTH  signed operand, FRAC_BITS fractional bits
//   k    out  3            normalisation shift
module cordic_norm_shift #(
  parameter int WORD_LENGTH = 18,
  parameter int FRAC_BITS   = 11,
  parameter int MAX_SHIFT   = 6
) (
  input  logic signed [WORD_LENGTH-1:0] din,
  output logic        [2:0]             k
);

  localparam logic signed [WORD_LENGTH-1:0] LIM_HI = WORD_LENGTH'((2 << FRAC_BITS) - 1);
  localparam logic signed [WORD_LENGTH-1:0] LIM_LO = WORD_LENGTH'(-(2 << FRAC_BITS));

  logic signed [WORD_LENGTH-1:0] shifted;

  // Scan from the largest shift down so the last hit is the smallest k.
  always_comb begin
    k       = 3'(MAX_SHIFT);
    shifted = din;
    for (int j = MAX_SHIFT; j >= 0; j--) begin
      shifted = din >>> j;
      if (shifted >= LIM_LO && shifted <= LIM_HI) begin
        k = 3'(j);
      end
    end
  end

endmodule

// File: rtl/multiply_cordic.sv
// Iterative linear-mode CORDIC multiplier (rotation mode): product = A * B.
// Operands and result are signed Q6.11. B is pre-normalised into [-2, 2),
// the micro-rotations accumulate A * (B / 2^k), and the result is scaled
// back by 2^k, rounded half-up and saturated.
// Ports:
//   CLK      in   1            clock, rising edge
//   RST      in   1            synchronous reset, active low
//   Enable   in   1            start strobe, sampled only when idle
//   Input_A  in   WORD_LENGTH  multiplicand, signed Q6.11
//   Input_B  in   WORD_LENGTH  multiplier, signed Q6.11
//   product  out  WORD_LENGTH  A*B, signed Q6.11, saturated
//   Valid    out  1            one-cycle pulse when product updates
//
// state | meaning
// IDLE  | waiting for Enable; operands captured on start
// NORM  | pick shift k for B, load x/y/z accumulators
// ITER  | one micro-rotation per cycle, ITERATIONS cycles
// DONE  | rescale, round, saturate, pulse Valid
module multiply_cordic
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int ITERATIONS  = 18,
  parameter int MAX_SHIFT   = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Enable,
  input  logic [WORD_LENGTH-1:0] Input_A,
  input  logic [WORD_LENGTH-1:0] Input_B,
  output logic [WORD_LENGTH-1:0] product,
  output logic                   Valid
);

  localparam int XW = WORD_LENGTH + ITERATIONS + 1;   // x/y accumulators
  localparam int ZW = WORD_LENGTH + MAX_SHIFT;        // angle accumulator
  localparam int ZF = FRAC_BITS + MAX_SHIFT;          // z fractional bits
  localparam int RW = XW + MAX_SHIFT + 1;             // rescaled result
  localparam int CW = $clog2(ITERATIONS + 1);

  localparam logic signed [RW-1:0] R_MAX = {{(RW-WORD_LENGTH){1'b0}}, SAT_MAX};
  localparam logic signed [RW-1:0] R_MIN = {{(RW-WORD_LENGTH){1'b1}}, SAT_MIN};

  cordic_state_e state_q, state_d;
  logic [WORD_LENGTH-1:0] a_q, a_d;
  logic [WORD_LENGTH-1:0] b_q, b_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] k_q, k_d;
  logic [WORD_LENGTH-1:0] product_q, product_d;
  logic valid_q, valid_d;

  logic [2:0] norm_k;
  logic signed [ZW-1:0] z_load;
  logic signed [ZW-1:0] z_step;
  logic signed [XW-1:0] x_shift;
  logic signed [RW-1:0] y_ext;
  logic signed [RW-1:0] r_full;
  logic signed [RW-1:0] r_rnd;

  cordic_norm_shift #(
    .WORD_LENGTH (WORD_LENGTH),
    .FRAC_BITS   (FRAC_BITS),
    .MAX_SHIFT   (MAX_SHIFT)
  ) u_norm (
    .din (b_q),
    .k   (norm_k)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    product_d = product_q;
    valid_d   = 1'b0;

    // Widening B by MAX_SHIFT zero LSBs keeps its value with ZF fraction
    // bits, so the arithmetic shift by k is exact.
    z_load  = {b_q, {MAX_SHIFT{1'b0}}};
    z_step  = ZW'(1) << (CW'(ZF) - cnt_q);
    x_shift = x_q >>> cnt_q;
    y_ext   = {{(RW-XW){y_q[XW-1]}}, y_q};
    // y carries FRAC_BITS+ITERATIONS fraction bits; add half an output LSB
    // before dropping ITERATIONS bits to round half-up.
    r_full  = (y_ext <<< k_q) + (RW'(1) <<< (ITERATIONS - 1));
    r_rnd   = r_full >>> ITERATIONS;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          a_d     = Input_A;
          b_d     = Input_B;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        x_d     = {{(XW-WORD_LENGTH-ITERATIONS){a_q[WORD_LENGTH-1]}}, a_q, {ITERATIONS{1'b0}}};
        y_d     = '0;
        z_d     = z_load >>> norm_k;
        k_d     = norm_k;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (!z_q[ZW-1]) begin
          y_d = y_q + x_shift;
          z_d = z_q - z_step;
        end else begin
          y_d = y_q - x_shift;
          z_d = z_q + z_step;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERATIONS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_rnd > R_MAX) begin
          product_d = SAT_MAX;
        end else if (r_rnd < R_MIN) begin
          product_d = SAT_MIN;
        end else begin
          product_d = r_rnd[WORD_LENGTH-1:0];
        end
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign product = product_q;
  assign Valid   = valid_q;

endmodule

// File: tb/tb_multiply_cordic.sv
module tb_multiply_cordic;
  import cordic_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Enable = 1'b0;
  logic [17:0] Input_A = '0;
  logic [17:0] Input_B = '0;
  logic [17:0] product;
  logic        Valid;

  int vectors = 0;
  int miscompares = 0;

  multiply_cordic dut (
    .CLK     (CLK),
    .RST     (RST),
    .Enable  (Enable),
    .Input_A (Input_A),
    .Input_B (Input_B),
    .product (product),
    .Valid   (Valid)
  );

  always #5 CLK = ~CLK;

  // Reference: exact integer product of two Q6.11 values, rounded half-up
  // to Q6.11 and clamped to the 18-bit signed range.
  function automatic logic [17:0] ref_mul(input logic [17:0] a, input logic [17:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = (p + 1024) >>> 11;
    if (p > 131071) p = 131071;
    if (p < -131072) p = -131072;
    return p[17:0];
  endfunction

  task automatic check_near(input string tag, input logic [17:0] got,
                            input logic [17:0] exp, input int tol);
    int d;
    logic ok;
    d = int'($signed(got)) - int'($signed(exp));
    ok = (d <= tol) && (d >= -tol);
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d (tol %0d)", tag,
             $signed(got), $signed(exp), tol);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Starts one operation (Enable sampled at edge E) and watches 30 cycles.
  // lat = number of edges after E until Valid is seen (-1 if never).
  task automatic run_op(input logic [17:0] a, input logic [17:0] b,
                        output logic [17:0] p, output int lat, output int pulses);
    @(negedge CLK);
    Enable = 1'b1; Input_A = a; Input_B = b;
    @(negedge CLK);
    Enable = 1'b0; Input_A = $urandom_range(0, 262143); Input_B = $urandom_range(0, 262143);
    lat = -1; pulses = 0; p = 'x;
    for (int n = 1; n <= 30; n++) begin
      @(negedge CLK);
      if (Valid) begin
        pulses++;
        if (lat < 0) begin lat = n; p = product; end
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [17:0] a, input logic [17:0] b,
                          input logic [17:0] exp, input int tol);
    logic [17:0] p;
    int lat, pulses;
    run_op(a, b, p, lat, pulses);
    check_int({tag, "_lat"}, lat, 20);
    check_int({tag, "_pulses"}, pulses, 1);
    check_near({tag, "_prod"}, p, exp, tol);
  endtask

  logic [17:0] p0, p1, ra, rb;
  int lat0, lat1, pulses;

  initial begin
    // Reset
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_int("rst_product", int'(product), 0);
    check_int("rst_valid", int'(Valid), 0);
    RST = 1'b1;

    // Directed cases
    op_check("a2_b3", 18'h01000, 18'h01800, 18'd12288, 2);
    op_check("half_half", 18'd1024, 18'd1024, 18'd512, 2);
    op_check("neg3_b2p5", 18'(-6144), 18'd5120, 18'h3C400, 2);
    op_check("sat_pos", 18'd81920, 18'd81920, SAT_MAX, 0);
    op_check("sat_neg", 18'd81920, 18'(-81920), SAT_MIN, 0);
    op_check("large_b", 18'd512, 18'd26290, 18'd6573, 2);
    op_check("b_min", ONE_Q, 18'h20000, 18'h20000, 2);
    op_check("a_zero", 18'd0, 18'd7777, 18'd0, 2);
    op_check("b_zero", 18'd4000, 18'd0, 18'd0, 2);

    // Enable re-asserted mid-operation with new operands is ignored
    @(negedge CLK);
    Enable = 1'b1; Input_A = 18'h01000; Input_B = 18'h01800;
    @(negedge CLK);
    Enable = 1'b0;
    lat0 = -1; pulses = 0; p0 = '0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 5) begin Enable = 1'b1; Input_A = 18'd1024; Input_B = 18'd1024; end
      if (n == 6) Enable = 1'b0;
      @(negedge CLK);
      if (Valid) begin
        pulses++;
        if (lat0 < 0) begin lat0 = n; p0 = product; end
      end
    end
    check_int("ignore_lat", lat0, 20);
    check_int("ignore_pulses", pulses, 1);
    check_near("ignore_prod", p0, 18'd12288, 2);

    // Enable held high: back-to-back operations
    @(negedge CLK);
    Enable = 1'b1; Input_A = 18'd3072; Input_B = 18'(-5000);
    @(negedge CLK);
    lat0 = -1; lat1 = -1; pulses = 0; p0 = '0; p1 = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (n == 41) Enable = 1'b0;
      if (Valid) begin
        pulses++;
        if (lat0 < 0) begin lat0 = n; p0 = product; end
        else if (lat1 < 0) begin lat1 = n; p1 = product; end
      end
    end
    check_int("hold_lat0", lat0, 20);
    check_int("hold_lat1", lat1, 41);
    check_int("hold_pulses", pulses, 2);
    check_near("hold_prod0", p0, ref_mul(18'd3072, 18'(-5000)), 2);
    check_near("hold_prod1", p1, ref_mul(18'd3072, 18'(-5000)), 2);

    // Reset in the middle of an operation
    @(negedge CLK);
    Enable = 1'b1; Input_A = 18'd10240; Input_B = 18'd10240;
    @(negedge CLK);
    Enable = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 35; n++) begin
      if (n == 10) RST = 1'b0;
      if (n == 11) RST = 1'b1;
      @(negedge CLK);
      if (Valid) pulses++;
    end
    check_int("abort_pulses", pulses, 0);
    check_int("abort_product", int'(product), 0);
    op_check("after_abort", ONE_Q, ONE_Q, ONE_Q, 2);

    // Randomised operands, |A| <= 2.0, B anywhere in range
    for (int i = 0; i < 20; i++) begin
      ra = 18'($signed($urandom_range(0, 8192)) - 4096);
      rb = 18'($urandom_range(0, 262143));
      op_check("rand", ra, rb, ref_mul(ra, rb), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
